pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage RISC-V pipeline.
- Detects load-use hazards, EX-stage control-flow redirects and data-memory wait states.
- Drives the PC write enable, IF/ID write/flush, ID/EX flush (the ID_EX R input) and a global hold for the EX/MEM and MEM/WB registers.
- Contains a wait-state FSM with timeout plus saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles on one data-memory access before the error state (>=2)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
MemRead_ex  in  1  instruction in EX is a load
rdAddr_ex  in  5  destination register of the EX instruction
rs1Addr_id  in  5  rs1 of the ID instruction
rs2Addr_id  in  5  rs2 of the ID instruction
rs1Used_id  in  1  ID instruction reads rs1
rs2Used_id  in  1  ID instruction reads rs2
Redirect_ex  in  1  taken branch / JAL / JALR resolved in EX
dmem_req_mem  in  1  MEM stage issues a data-memory access
dmem_ready  in  1  data memory completes the access this cycle
PCWrite  out  1  PC update enable
IFIDWrite  out  1  IF/ID load enable
IFID_flush  out  1  clear IF/ID to NOP
IDEX_flush  out  1  clear ID/EX (bubble); wired to ID_EX R
pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB contents
mem_err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles with PCWrite=0
flush_cnt  out  CNT_W  cycles with IFID_flush=1

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. All state and counter registers are cleared asynchronously when rst_n=0.
- Reset values: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_err=0.
- All control outputs are combinational from state and inputs, so a hazard takes effect in the same cycle.
- Internal terms:
  - memstall = dmem_req_mem & ~dmem_ready
  - loaduse = MemRead_ex & (rdAddr_ex!=0) & ((rs1Used_id & rs1Addr_id==rdAddr_ex) | (rs2Used_id & rs2Addr_id==rdAddr_ex))
- RUN priority, highest first:
  1. memstall: PCWrite=0, IFIDWrite=0, pipe_hold=1, both flushes=0. Redirect and loaduse are ignored because the registers freeze and the condition is re-evaluated after the wait.
  2. Redirect_ex: PCWrite=1, IFIDWrite=1, IFID_flush=1, IDEX_flush=1. A simultaneous loaduse is ignored, since the stalled instruction is squashed.
  3. loaduse: PCWrite=0, IFIDWrite=0, IDEX_flush=1, IFID_flush=0. This gives exactly one bubble; the next cycle the load is in MEM and loaduse is false.
  4. Otherwise PCWrite=1, IFIDWrite=1, all other control outputs 0.
- RUN -> MEM_WAIT when memstall; wait_cnt<=1.
- MEM_WAIT:
  - Outputs are as for memstall regardless of dmem_ready.
  - If dmem_ready: -> RUN, wait_cnt<=0. The access completes and the pipeline advances the next cycle.
  - Else if wait_cnt==MEM_TIMEOUT-1: -> ERR, mem_err<=1.
  - Else wait_cnt<=wait_cnt+1.
- Consequence: dmem_ready asserted in the first cycle of a request causes no stall. A response on wait cycle k produces k+1 frozen cycles including the completion cycle.
- ERR: PCWrite=0, IFIDWrite=0, pipe_hold=1, flushes=0. mem_err stays 1 and the block stays in ERR until rst_n is asserted.
- Counters:
  - stall_cnt increments each cycle PCWrite==0.
  - flush_cnt increments each cycle IFID_flush==1.
  - Both saturate at all-ones and never wrap.
- Reset mid-wait: state returns to RUN immediately (asynchronous reset); outputs take RUN values derived from current inputs.
- rdAddr_ex==0: never a hazard (x0).

Decomposition:
- Shared package holds:
  - state encoding localparams: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2
  - the x0 register-address constant
- One natural sub-module, sat_counter (parameter W; ports clk, rst_n, inc, q). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
1. Load-use: MemRead_ex=1, rdAddr_ex=5, rs2Used_id=1, rs2Addr_id=5, one cycle -> PCWrite=0, IFIDWrite=0, IDEX_flush=1 for exactly 1 cycle; stall_cnt 0->1.
2. rdAddr_ex=0 with matching rs1Addr_id=0, MemRead_ex=1 -> no stall; all enables 1, stall_cnt unchanged.
3. Redirect_ex=1 together with loaduse -> IFID_flush=1, IDEX_flush=1, PCWrite=1; flush_cnt +1, stall_cnt unchanged.
4. dmem_req_mem=1, dmem_ready asserted on the 3rd cycle, Redirect_ex=1 throughout -> pipe_hold=1 and PCWrite=0 for 3 cycles, no flushes while held, state back to RUN; stall_cnt +3.
5. dmem_req_mem=1, dmem_ready=0 for 20 cycles with MEM_TIMEOUT=16 -> mem_err rises after 16 held cycles and stays 1; rst_n pulse low clears mem_err, counters and state.
6. Preload the counter to all-ones minus 1 via a long stall (CNT_W=4 build), continue stalling -> stall_cnt holds at 4'hF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [4:0] X0_ADDR = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, EX redirects,
// data-memory wait states with timeout, plus stall/flush performance counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MemRead_ex,
   input  logic [4:0]       rdAddr_ex,
   input  logic [4:0]       rs1Addr_id,
   input  logic [4:0]       rs2Addr_id,
   input  logic             rs1Used_id,
   input  logic             rs2Used_id,
   input  logic             Redirect_ex,
   input  logic             dmem_req_mem,
   input  logic             dmem_ready,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             pipe_hold,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   state_t         state, state_nxt;
   logic [WCW-1:0] wait_cnt, wait_nxt;
   logic           err_nxt;
   logic           memstall, loaduse;

   assign memstall = dmem_req_mem & ~dmem_ready;
   assign loaduse  = MemRead_ex & (rdAddr_ex != X0_ADDR) &
                     ((rs1Used_id & (rs1Addr_id == rdAddr_ex)) |
                      (rs2Used_id & (rs2Addr_id == rdAddr_ex)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         mem_err  <= err_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      wait_nxt   = wait_cnt;
      err_nxt    = mem_err;
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFID_flush = 1'b0;
      IDEX_flush = 1'b0;
      pipe_hold  = 1'b0;
      case (state)
         RUN: begin
            // A memory stall freezes everything; redirect/load-use are re-evaluated afterwards.
            if (memstall) begin
               PCWrite   = 1'b0;
               IFIDWrite = 1'b0;
               pipe_hold = 1'b1;
               state_nxt = MEM_WAIT;
               wait_nxt  = WCW'(1);
            end else if (Redirect_ex) begin
               IFID_flush = 1'b1;
               IDEX_flush = 1'b1;
            end else if (loaduse) begin
               PCWrite    = 1'b0;
               IFIDWrite  = 1'b0;
               IDEX_flush = 1'b1;
            end
         end
         MEM_WAIT: begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            pipe_hold = 1'b1;
            if (dmem_ready) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
               state_nxt = ERR;
               err_nxt   = 1'b1;
            end else begin
               wait_nxt = wait_cnt + WCW'(1);
            end
         end
         default: begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            pipe_hold = 1'b1;
         end
      endcase
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~PCWrite),
      .q     (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (IFID_flush),
      .q     (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a behavioural reference model.
module tb_pipe_hazard_ctrl;

   localparam int TO    = 16;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          MemRead_ex, rs1Used_id, rs2Used_id, Redirect_ex, dmem_req_mem, dmem_ready;
   logic [4:0]    rdAddr_ex, rs1Addr_id, rs2Addr_id;
   logic          PCWrite, IFIDWrite, IFID_flush, IDEX_flush, pipe_hold, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: number of cycles already waited on the current access (0 = none).
   int m_wait, m_stall, m_flush;
   bit m_err;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
      .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
      .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
      .Redirect_ex(Redirect_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFID_flush(IFID_flush),
      .IDEX_flush(IDEX_flush), .pipe_hold(pipe_hold), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
   endtask

   // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model at the edge.
   task automatic step(input bit mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input bit u1, input bit u2, input bit redir, input bit req, input bit rdy);
      bit hazard, frozen;
      bit e_pc, e_ifw, e_iff, e_idf, e_hold;
      MemRead_ex = mr; rdAddr_ex = rd; rs1Addr_id = r1; rs2Addr_id = r2;
      rs1Used_id = u1; rs2Used_id = u2; Redirect_ex = redir;
      dmem_req_mem = req; dmem_ready = rdy;
      hazard = mr && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
      frozen = m_err || m_wait > 0 || (req && !rdy);
      e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0;
      if (frozen) begin
         e_pc = 0; e_ifw = 0; e_hold = 1;
      end else if (redir) begin
         e_iff = 1; e_idf = 1;
      end else if (hazard) begin
         e_pc = 0; e_ifw = 0; e_idf = 1;
      end
      @(negedge clk);
      check("PCWrite",    32'(PCWrite),    32'(e_pc));
      check("IFIDWrite",  32'(IFIDWrite),  32'(e_ifw));
      check("IFID_flush", 32'(IFID_flush), 32'(e_iff));
      check("IDEX_flush", 32'(IDEX_flush), 32'(e_idf));
      check("pipe_hold",  32'(pipe_hold),  32'(e_hold));
      check("mem_err",    32'(mem_err),    32'(m_err));
      check("stall_cnt",  32'(stall_cnt),  32'(m_stall));
      check("flush_cnt",  32'(flush_cnt),  32'(m_flush));
      @(posedge clk);
      if (!e_pc && m_stall < CMAX) m_stall++;
      if (e_iff && m_flush < CMAX) m_flush++;
      if (!m_err) begin
         if (m_wait == 0) begin
            if (req && !rdy) m_wait = 1;
         end else if (rdy) begin
            m_wait = 0;
         end else if (m_wait == TO - 1) begin
            m_err = 1;
            m_wait = 0;
         end else begin
            m_wait++;
         end
      end
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset pulse taken mid-cycle; state and counters must clear without a clock edge.
   task automatic reset_pulse();
      rst_n = 1'b0;
      #2;
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      check("rst_mem_err",   32'(mem_err),   32'd0);
      check("rst_pipe_hold", 32'(pipe_hold), 32'(dmem_req_mem & ~dmem_ready));
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
      rs1Used_id = 0; rs2Used_id = 0; Redirect_ex = 0; dmem_req_mem = 0; dmem_ready = 0;
      model_reset();
      #2;
      check("init_stall_cnt", 32'(stall_cnt), 32'd0);
      check("init_flush_cnt", 32'(flush_cnt), 32'd0);
      check("init_mem_err",   32'(mem_err),   32'd0);
      check("init_PCWrite",   32'(PCWrite),   32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // load-use on rs2: a single bubble
      step(1, 5, 0, 5, 0, 1, 0, 0, 0);
      idle();
      check("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);

      // x0 destination never stalls
      step(1, 0, 0, 0, 1, 1, 0, 0, 0);
      idle();

      // redirect wins over load-use
      step(1, 7, 7, 0, 1, 0, 1, 0, 0);
      idle();
      check("redir_flush_cnt", 32'(flush_cnt), 32'd1);

      // memory response on the 3rd cycle with redirect held high
      step(0, 0, 0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("memwait_stall_cnt", 32'(stall_cnt), 32'd4);

      // ready in the first request cycle: no stall
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);

      // timeout into the sticky error state, then reset
      reset_pulse();
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("timeout_mem_err", 32'(mem_err), 32'd1);
      idle();
      reset_pulse();
      idle();

      // stall counter saturation
      for (int i = 0; i < 20; i++) step(1, 3, 3, 0, 1, 0, 0, 0, 0);
      check("sat_stall_cnt", 32'(stall_cnt), 32'(CMAX));
      idle();

      // randomized traffic with occasional asynchronous resets
      reset_pulse();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) reset_pulse();
         step(bit'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
